// File: rtl/calc_pkg.sv
// Shared opcode and state encodings for the RPN calculator engine and the
// calculator top level that maps buttons/switches onto commands.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_PUSH   = 3'b000,
    OP_APPEND = 3'b001,
    OP_POP    = 3'b010,
    OP_DUP    = 3'b011,
    OP_SWAP   = 3'b100,
    OP_ADD    = 3'b101,
    OP_SUB    = 3'b110,
    OP_CLEAR  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2
  } state_e;

endpackage

// File: rtl/stack_ram.sv
// Simple dual-port stack storage: one synchronous write port and one read
// port whose data is registered one cycle after the address is presented.
module stack_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1023,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/rpn_core.sv
// RPN stack-calculator engine: top-of-stack register plus RAM for the entries
// below it, with a three-state sequencer for operations that need a RAM read.
module rpn_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int IMM_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [IMM_W-1:0]           cmd_imm,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] size,
  output logic                       empty,
  output logic                       error
);

  localparam int SZ_W  = $clog2(DEPTH + 1);
  localparam int RAM_N = DEPTH - 1;
  localparam int AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [SZ_W-1:0]  size_q, size_d;
  logic             err_q, err_d;
  logic [AW-1:0]    raddr_q, raddr_d;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  logic accept, is_full, is_empty, has_two;
  op_e  op_in;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign op_in     = op_e'(cmd_op);
  assign is_full   = (size_q == SZ_W'(DEPTH));
  assign is_empty  = (size_q == '0);
  assign has_two   = (size_q >= SZ_W'(2));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    top_d     = top_q;
    size_d    = size_q;
    err_d     = err_q;
    raddr_d   = raddr_q;
    ram_we    = 1'b0;
    ram_waddr = AW'(size_q - SZ_W'(1));
    ram_wdata = top_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          raddr_d = AW'(size_q - SZ_W'(2));
          case (op_in)
            OP_PUSH: begin
              if (is_full) begin
                err_d = 1'b1;
              end else begin
                ram_we = !is_empty;
                top_d  = {{(WIDTH-IMM_W){1'b0}}, cmd_imm};
                size_d = size_q + SZ_W'(1);
              end
            end
            OP_APPEND: begin
              if (is_empty) err_d = 1'b1;
              else          top_d = {top_q[WIDTH-IMM_W-1:0], cmd_imm};
            end
            OP_POP: begin
              if (is_empty) begin
                err_d = 1'b1;
              end else if (!has_two) begin
                top_d  = '0;
                size_d = '0;
              end else begin
                state_d = S_RD;
              end
            end
            OP_DUP: begin
              if (is_empty || is_full) begin
                err_d = 1'b1;
              end else begin
                ram_we = 1'b1;
                size_d = size_q + SZ_W'(1);
              end
            end
            OP_SWAP, OP_ADD, OP_SUB: begin
              if (!has_two) err_d   = 1'b1;
              else          state_d = S_RD;
            end
            OP_CLEAR: begin
              top_d  = '0;
              size_d = '0;
              err_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end

      S_RD: state_d = S_EX;

      // Second-from-top is now on ram_rdata; commit the result.
      S_EX: begin
        state_d = S_IDLE;
        case (op_q)
          OP_POP: begin
            top_d  = ram_rdata;
            size_d = size_q - SZ_W'(1);
          end
          OP_SWAP: begin
            top_d     = ram_rdata;
            ram_we    = 1'b1;
            ram_waddr = AW'(size_q - SZ_W'(2));
          end
          OP_ADD: begin
            top_d  = ram_rdata + top_q;
            size_d = size_q - SZ_W'(1);
          end
          OP_SUB: begin
            top_d  = ram_rdata - top_q;
            size_d = size_q - SZ_W'(1);
          end
          default: ;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      top_q   <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      size_q  <= size_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    raddr_q <= raddr_d;
  end

  // Reset suppresses any write-back in flight so an abandoned op leaves RAM untouched.
  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (RAM_N),
    .AW    (AW)
  ) u_stack_ram (
    .clk     (clk),
    .we_i    (ram_we && !reset),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (raddr_q),
    .rdata_o (ram_rdata)
  );

  assign top   = top_q;
  assign size  = size_q;
  assign empty = is_empty;
  assign error = err_q;

endmodule

// File: tb/tb_rpn_core.sv
// Scoreboard bench for rpn_core: a queue-based stack model predicts each
// command's result and latency; a monitor checks the DUT as commands retire.
module tb_rpn_core;
  import calc_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int IMM_W = 8;
  localparam int SZ_W  = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [IMM_W-1:0] cmd_imm;
  logic [WIDTH-1:0] top;
  logic [SZ_W-1:0]  size;
  logic             empty;
  logic             error;

  rpn_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_imm   (cmd_imm),
    .top       (top),
    .size      (size),
    .empty     (empty),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [31:0] top;
    int          size;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mstk[$];
  logic        merr;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t snapshot(input int lat);
    exp_t e;
    e.lat  = lat;
    e.size = mstk.size();
    e.top  = (mstk.size() > 0) ? mstk[$] : 32'h0;
    e.err  = merr;
    return e;
  endfunction

  // Whole-stack model: the queue holds every entry, top at the back.
  function automatic exp_t model_step(input logic [2:0] op, input logic [7:0] imm);
    int          n = mstk.size();
    int          lat = 1;
    logic [31:0] a, b, t;
    case (op)
      3'd0: if (n == DEPTH) merr = 1'b1; else mstk.push_back({24'h0, imm});
      3'd1: if (n == 0) merr = 1'b1;
            else begin t = mstk[n-1]; mstk[n-1] = {t[23:0], imm}; end
      3'd2: if (n == 0) merr = 1'b1;
            else begin if (n >= 2) lat = 3; void'(mstk.pop_back()); end
      3'd3: if (n == 0 || n == DEPTH) merr = 1'b1; else mstk.push_back(mstk[n-1]);
      3'd4: if (n < 2) merr = 1'b1;
            else begin a = mstk[n-1]; mstk[n-1] = mstk[n-2]; mstk[n-2] = a; lat = 3; end
      3'd5: if (n < 2) merr = 1'b1;
            else begin a = mstk.pop_back(); b = mstk.pop_back(); mstk.push_back(b + a); lat = 3; end
      3'd6: if (n < 2) merr = 1'b1;
            else begin a = mstk.pop_back(); b = mstk.pop_back(); mstk.push_back(b - a); lat = 3; end
      default: begin mstk.delete(); merr = 1'b0; end
    endcase
    return snapshot(lat);
  endfunction

  task automatic wait_ready();
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      $display("FAIL ready_timeout: cmd_ready=%0b expected 1", cmd_ready);
      $fatal(1, "cmd_ready stuck low");
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] imm);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    @(posedge clk);
    sb.push_back(model_step(op, imm));
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_imm   = 8'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || !cmd_ready) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic reset_dut();
    drain();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mstk.delete();
    merr = 1'b0;
    @(negedge clk);
    chk("rst_top",   top,         32'h0);
    chk("rst_size",  32'(size),   32'd0);
    chk("rst_empty", 32'(empty),  32'd1);
    chk("rst_error", 32'(error),  32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Accept ADD, then assert reset while the engine is in RD.
  task automatic abort_add();
    exp_t e;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = 3'(OP_ADD);
    cmd_imm   = 8'h00;
    @(posedge clk);
    mstk.delete();
    merr = 1'b0;
    e = snapshot(2);
    sb.push_back(e);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: each accepted command retires when cmd_ready is next seen high.
  initial begin
    exp_t e;
    int   cyc;
    forever begin
      @(posedge clk);
      if (cmd_valid && cmd_ready && !reset) begin
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!cmd_ready && cyc < 8);
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", 32'(cyc),   32'(e.lat));
          chk("top",     top,        e.top);
          chk("size",    32'(size),  32'(e.size));
          chk("empty",   32'(empty), 32'(e.size == 0));
          chk("error",   32'(error), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_imm   = 8'h00;
    merr      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("init_top",   top,             32'h0);
    chk("init_size",  32'(size),       32'd0);
    chk("init_empty", 32'(empty),      32'd1);
    chk("init_error", 32'(error),      32'd0);
    chk("init_ready", 32'(cmd_ready),  32'd1);

    // Back-to-back push/append.
    issue(OP_PUSH, 8'h12); issue(OP_APPEND, 8'h34); issue(OP_APPEND, 8'h56);
    chk("append_model_top", mstk[$], 32'h00123456);

    reset_dut();
    issue(OP_PUSH, 8'd5); issue(OP_PUSH, 8'd7); issue(OP_SUB, 8'h00);
    issue(OP_PUSH, 8'd3); issue(OP_ADD, 8'h00);

    reset_dut();
    issue(OP_PUSH, 8'd1); issue(OP_PUSH, 8'd2); issue(OP_SWAP, 8'h00); issue(OP_POP, 8'h00);

    // Full/empty boundaries and sticky error.
    reset_dut();
    for (int i = 1; i <= 4; i++) issue(OP_PUSH, 8'(i));
    issue(OP_PUSH, 8'd9); issue(OP_DUP, 8'h00);
    for (int i = 0; i < 4; i++) issue(OP_POP, 8'h00);
    issue(OP_POP, 8'h00); issue(OP_CLEAR, 8'h00);

    reset_dut();
    issue(OP_PUSH, 8'd1); issue(OP_ADD, 8'h00);

    reset_dut();
    issue(OP_PUSH, 8'd1); issue(OP_PUSH, 8'd2);
    abort_add();
    issue(OP_PUSH, 8'd6);

    // Randomised traffic, push-biased so the stack reaches full regularly.
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      int       r;
      logic [2:0] op;
      r = int'($urandom_range(0, 19));
      if (r < 6)       op = 3'(OP_PUSH);
      else if (r == 19) op = 3'(OP_CLEAR);
      else             op = 3'($urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(op, 8'($urandom));
    end

    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rpn_core.md
# rpn_core

Parametrised RPN stack-calculator engine. It replaces the fixed push/append/pop/dup/swap controller used in the calculator top level, and adds arithmetic (add, sub), a clear command, a configurable word width and stack depth, and a valid/ready command handshake. It sits between the button/switch synchronisers and the seven-segment display driver.

## Interface
Parameters:
- `WIDTH`, default 32: data word width.
- `DEPTH`, default 1024: maximum number of stack entries, including the top. Must be ≥ 2.
- `IMM_W`, default 8: immediate width. Must be < `WIDTH`.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: engine can accept a command.
- `cmd_op` input 3: opcode.
- `cmd_imm` input `IMM_W`: immediate for PUSH and APPEND.
- `top` output `WIDTH`: top-of-stack value; 0 when empty.
- `size` output `$clog2(DEPTH+1)`: entry count.
- `empty` output 1: `size == 0`.
- `error` output 1: sticky error flag.

## Operation
- Storage: a `top` register plus `stack_ram` holding entries below the top. Entry i (0 = bottom) is at address i; the top is never stored in RAM.
- A command is accepted on a `clk` edge with `cmd_valid && cmd_ready`.
- Opcodes:
  - 000 PUSH: `top <= zext(imm)`; old top written to `ram[size-1]` if size > 0; `size++`. Error if full.
  - 001 APPEND: `top <= {top[WIDTH-IMM_W-1:0], imm}`. Error if empty.
  - 010 POP:
    - size 1: `top <= 0`, size 0.
    - size ≥ 2: `top <= ram[size-2]`, `size--`.
    - Error if empty.
  - 011 DUP: `ram[size-1] <= top`, `size++`. Error if empty or full.
  - 100 SWAP: `top <= ram[size-2]`, `ram[size-2] <= old top`. Error if size < 2.
  - 101 ADD: `top <= ram[size-2] + top` mod 2^WIDTH, `size--`. Error if size < 2.
  - 110 SUB: `top <= ram[size-2] - top` mod 2^WIDTH (second minus top), `size--`. Error if size < 2.
  - 111 CLEAR: size 0, top 0, error 0.
- On an error condition: stack contents, `top` and `size` are unchanged, and `error <= 1`.
- `error` stays set until CLEAR or `reset`. Commands continue to execute normally while `error` is high.
- State machine: IDLE, RD, EX.
  - IDLE → RD on acceptance of POP with size ≥ 2, SWAP, ADD or SUB (no error). Read address `size-2` is registered at that edge.
  - RD → EX unconditionally.
  - EX → IDLE: commit `top`, `size` and the SWAP write-back.
  - All other accepted commands, including every error case, complete in IDLE.
- `cmd_ready = (state == IDLE)`.

## Timing
- Reset values, from the first edge with `reset` high: state IDLE, `top` 0, `size` 0, `empty` 1, `error` 0, `cmd_ready` 1. RAM contents are not reset.
- Reset mid-operation (RD or EX) abandons the operation with no write-back; the engine is IDLE after the reset edge.
- Single-cycle ops: accept at edge k; new `top`/`size`/`error` visible after edge k. `cmd_ready` stays high, so back-to-back accepts are allowed.
- Multi-cycle ops: accept at edge k; `cmd_ready` is low after edges k and k+1; results are visible after edge k+2; `cmd_ready` is high after edge k+2.
- `stack_ram`: one write port and one read port; synchronous write; read data registered one cycle after the address.
  - A write and a read in the same cycle never target the same address.
  - The SWAP write-back occurs in EX, after the read has completed.
- `cmd_op` and `cmd_imm` are sampled only at the acceptance edge and may change afterwards.
- Full boundary: `size == DEPTH`. Top occupies the register; the RAM has `DEPTH-1` words.

## Structure
- Package `calc_pkg`: opcode constants (`OP_PUSH` … `OP_CLEAR`) and state encodings (`S_IDLE`, `S_RD`, `S_EX`). The top level uses it to map buttons and switches onto opcodes.
- Sub-module `stack_ram`, parameters `WIDTH` and `DEPTH-1`: inferable block RAM.
- Everything else lives in `rpn_core`.

## Test plan
All scenarios use WIDTH=32, DEPTH=4, IMM_W=8.
- Reset, then PUSH 0x12, APPEND 0x34, APPEND 0x56 back-to-back → `top` = 0x00123456, `size` = 1, `cmd_ready` never low.
- PUSH 5, PUSH 7, SUB → `cmd_ready` low for 2 cycles; `top` = 0xFFFFFFFE, `size` = 1. Then PUSH 3, ADD → `top` = 0x00000001.
- PUSH 1, PUSH 2, SWAP, POP → after SWAP `top` = 1; after POP `top` = 2, `size` = 1.
- PUSH ×4 (1,2,3,4), then PUSH 9 and DUP → `error` = 1, `top` = 4, `size` = 4. Then POP ×4 → `size` 0, `top` 0, `error` still 1. Then POP → `error` 1, state unchanged. Then CLEAR → `error` 0.
- PUSH 1, then ADD with size 1 → single cycle, `error` = 1, `top` = 1, `size` = 1.
- PUSH 1, PUSH 2, ADD; assert `reset` during RD → after reset `size` 0, `top` 0, `cmd_ready` 1. A subsequent PUSH 6 gives `top` 6, `size` 1.
